// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine keypad/display path.
// Holds key codes, entry FSM states, redlight codes and the keypad map.
package vend_pkg;

  localparam logic [3:0] KEY_A   = 4'hA;
  localparam logic [3:0] KEY_B   = 4'hB;
  localparam logic [3:0] KEY_C   = 4'hC;
  localparam logic [3:0] KEY_D   = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;

  localparam logic [1:0] RL_OK    = 2'b00;
  localparam logic [1:0] RL_OVF   = 2'b01;
  localparam logic [1:0] RL_EMPTY = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StOne,
    StTwo
  } entry_state_e;

  // Snapshot bit index (row*4+col) to key code.
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:    k = 4'd1;
      4'd1:    k = 4'd2;
      4'd2:    k = 4'd3;
      4'd3:    k = KEY_A;
      4'd4:    k = 4'd4;
      4'd5:    k = 4'd5;
      4'd6:    k = 4'd6;
      4'd7:    k = KEY_B;
      4'd8:    k = 4'd7;
      4'd9:    k = 4'd8;
      4'd10:   k = 4'd9;
      4'd11:   k = KEY_C;
      4'd12:   k = KEY_CLR;
      4'd13:   k = 4'd0;
      4'd14:   k = KEY_ENT;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad matrix, debounces full-scan snapshots and
// emits a one-cycle key event when a single key is pressed from all-released.
module keypad_scanner
  import vend_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_event
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE);

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      col_idx_q;
  logic [15:0]     raw_q, raw_d;
  logic [15:0]     prev_q, stable_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      key_code_q;
  logic            key_event_q;
  logic            slot_end, scan_end, accept, fire;
  logic [3:0]      hit_idx;

  assign slot_end  = (div_q == DivLast);
  assign scan_end  = slot_end && (col_idx_q == 2'd3);
  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_event = key_event_q;

  // Merge the current column's pressed rows into the snapshot on the slot's last cycle.
  always_comb begin
    raw_d = raw_q;
    if (slot_end) begin
      raw_d[{2'd0, col_idx_q}] = ~row_s2_q[0];
      raw_d[{2'd1, col_idx_q}] = ~row_s2_q[1];
      raw_d[{2'd2, col_idx_q}] = ~row_s2_q[2];
      raw_d[{2'd3, col_idx_q}] = ~row_s2_q[3];
    end
  end

  always_comb begin
    if (raw_d == prev_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = CntW'(1);
    end
  end

  always_comb begin
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (raw_d[i]) hit_idx = 4'(i);
    end
  end

  assign accept = scan_end && (cnt_d == CntMax);
  // Event only on all-released -> exactly one key, so a held key fires once.
  assign fire   = accept && (stable_q == 16'h0) && (raw_d != 16'h0) &&
                  ((raw_d & (raw_d - 16'h1)) == 16'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      raw_q       <= 16'h0;
      prev_q      <= 16'h0;
      stable_q    <= 16'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_event_q <= 1'b0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      raw_q       <= raw_d;
      key_event_q <= fire;
      if (fire) key_code_q <= keymap(hit_idx);
      if (slot_end) begin
        div_q     <= '0;
        col_idx_q <= col_idx_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (scan_end) begin
        prev_q <= raw_d;
        cnt_q  <= cnt_d;
        if (accept) stable_q <= raw_d;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry block: assembles up to two decimal digits into a product code
// and reports the in-progress entry and status for the seven-segment display.
module keypad_entry
  import vend_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [10:0] entry,
  output logic [1:0]  redlight,
  output logic [6:0]  code,
  output logic        code_valid
);

  entry_state_e state_q;
  logic [6:0]   entry_q;
  logic [6:0]   code_q;
  logic [1:0]   redlight_q;
  logic         code_valid_q;
  logic [3:0]   key_code;
  logic         key_event;
  logic [6:0]   acc;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_event (key_event)
  );

  // Two digits never exceed 99, so 7 bits hold the result without overflow.
  assign acc = entry_q * 7'd10 + {3'b000, key_code};

  assign entry      = {4'b0000, entry_q};
  assign redlight   = redlight_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      entry_q      <= 7'd0;
      code_q       <= 7'd0;
      redlight_q   <= RL_OK;
      code_valid_q <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      if (code_valid_q) begin
        // Entry stays visible during the strobe cycle, then clears.
        entry_q <= 7'd0;
        state_q <= StIdle;
      end else if (key_event) begin
        if (key_code <= 4'd9) begin
          redlight_q <= RL_OK;
          unique case (state_q)
            StIdle: begin
              entry_q <= {3'b000, key_code};
              state_q <= StOne;
            end
            StOne: begin
              entry_q <= acc;
              state_q <= StTwo;
            end
            StTwo:   redlight_q <= RL_OVF;
            default: state_q <= StIdle;
          endcase
        end else if (key_code == KEY_ENT) begin
          if (state_q == StIdle) begin
            redlight_q <= RL_EMPTY;
          end else begin
            redlight_q   <= RL_OK;
            code_q       <= entry_q;
            code_valid_q <= 1'b1;
          end
        end else if (key_code == KEY_CLR) begin
          state_q    <= StIdle;
          entry_q    <= 7'd0;
          redlight_q <= RL_OK;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a behavioural keypad matrix driven by a
// pressed-key mask, with hand-computed expectations checked by assertions.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [10:0] entry;
  logic [1:0]  redlight;
  logic [6:0]  code;
  logic        code_valid;

  logic [15:0] pressed = 16'h0;
  int total = 0;
  int bad = 0;
  int cv_count = 0;
  int cv0;

  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6;
  localparam int K7 = 8, K9 = 10, KSTAR = 12, KHASH = 14;
  localparam int SCAN = 16;
  localparam int HOLD = 4 * SCAN;

  keypad_entry #(
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .col        (col),
    .entry      (entry),
    .redlight   (redlight),
    .code       (code),
    .code_valid (code_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[r*4+c]) row[r] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) if (code_valid) cv_count <= cv_count + 1;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tap(input int k);
    pressed = 16'h0;
    pressed[k] = 1'b1;
    cycles(HOLD);
    pressed = 16'h0;
    cycles(HOLD);
  endtask

  initial begin
    cycles(3);
    check("rst_col", 32'(col), 32'hE);
    check("rst_entry", 32'(entry), 32'd0);
    check("rst_red", 32'(redlight), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_cv", 32'(code_valid), 32'd0);
    rst_n = 1'b1;
    cycles(2 * SCAN);

    // 4, 2, # -> code 42
    tap(K4);
    check("entry_4", 32'(entry), 32'd4);
    tap(K2);
    check("entry_42", 32'(entry), 32'd42);
    cv0 = cv_count;
    tap(KHASH);
    check("code_42", 32'(code), 32'd42);
    check("cv_once_42", 32'(cv_count - cv0), 32'd1);
    check("entry_clr_42", 32'(entry), 32'd0);

    // Bouncing 7: toggles every scan for five scans, never stable.
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0;
      pressed[K7] = (i % 2 == 0);
      cycles(SCAN);
    end
    pressed = 16'h0;
    cycles(HOLD);
    check("bounce_entry", 32'(entry), 32'd0);
    check("bounce_red", 32'(redlight), 32'd0);

    // 1, 2, 3 -> overflow on third digit, then enter.
    tap(K1);
    tap(K2);
    tap(K3);
    check("ovf_entry", 32'(entry), 32'd12);
    check("ovf_red", 32'(redlight), 32'd1);
    cv0 = cv_count;
    tap(KHASH);
    check("code_12", 32'(code), 32'd12);
    check("cv_once_12", 32'(cv_count - cv0), 32'd1);
    check("red_ok_12", 32'(redlight), 32'd0);
    check("entry_clr_12", 32'(entry), 32'd0);

    // Empty enter, letter ignored, then clear.
    cv0 = cv_count;
    tap(KHASH);
    check("empty_red", 32'(redlight), 32'd2);
    check("empty_cv", 32'(cv_count - cv0), 32'd0);
    check("empty_code", 32'(code), 32'd12);
    tap(KA);
    check("letter_red", 32'(redlight), 32'd2);
    check("letter_entry", 32'(entry), 32'd0);
    tap(KSTAR);
    check("clr_red", 32'(redlight), 32'd0);

    // Two keys together, then release one: no event either way.
    pressed = 16'h0;
    pressed[K5] = 1'b1;
    pressed[K6] = 1'b1;
    cycles(HOLD);
    check("multi_entry", 32'(entry), 32'd0);
    pressed[K6] = 1'b0;
    cycles(HOLD);
    check("multi_rel_entry", 32'(entry), 32'd0);
    pressed = 16'h0;
    cycles(HOLD);
    check("multi_end_entry", 32'(entry), 32'd0);

    // Held 9 for 20 scans -> one event only.
    pressed = 16'h0;
    pressed[K9] = 1'b1;
    cycles(20 * SCAN);
    check("held_9", 32'(entry), 32'd9);
    check("held_red", 32'(redlight), 32'd0);

    // Asynchronous reset mid-entry.
    cv0 = cv_count;
    #2;
    rst_n = 1'b0;
    pressed = 16'h0;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_entry", 32'(entry), 32'd0);
    check("mid_rst_red", 32'(redlight), 32'd0);
    check("mid_rst_code", 32'(code), 32'd0);
    check("mid_rst_cv", 32'(code_valid), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(HOLD);
    check("post_rst_entry", 32'(entry), 32'd0);
    check("post_rst_cv", 32'(cv_count - cv0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
